// File: rtl/movegen_square_seq.sv
// Per-square move generator with registered destination capture and a valid/ready move-record drain.
// Optional build macro MOVEGEN_PROMO_EN: promotion pending bits emit four records (Q, R, B, N).
module movegen_square_seq #(
  parameter int RANK      = 1,
  parameter int FILE      = 1,
  parameter int NRANKS    = 8,
  parameter int NFILES    = 8,
  parameter int KING_FILE = 5,
  parameter int SQ_W      = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_pos_valid,
  input  logic [3:0]      in_pos_data,
  output logic [3:0]      out_pos_data,
  input  logic            wtp,
  input  logic            emit_move,
  input  logic            capture,
  input  logic            flush,
  input  logic [3:0]      i_castle_rights,
  output logic [1:0]      o_pawn_push,
  input  logic [1:0]      i_pawn_push,
  output logic [3:0]      o_pawn_take,
  input  logic [3:0]      i_pawn_take,
  output logic [7:0]      o_king,
  input  logic [7:0]      i_king,
  output logic [7:0]      o_slide,
  input  logic [7:0]      i_slide,
  output logic [7:0]      o_knight,
  input  logic [7:0]      i_knight,
  output logic            o_castle_e,
  output logic            o_castle_w,
  input  logic            i_castle_e,
  input  logic            i_castle_w,
  output logic            o_busy,
  output logic            o_mv_valid,
  input  logic            i_mv_ready,
  output logic [SQ_W-1:0] o_mv_to,
  output logic [2:0]      o_mv_kind,
  output logic [2:0]      o_mv_dir,
  output logic [1:0]      o_mv_promo
);

  localparam logic [SQ_W-1:0] TO_SQ = SQ_W'((RANK - 1) * NFILES + (FILE - 1));
  localparam bit BACK_RANK = (RANK == 1) || (RANK == NRANKS);
  localparam bit KING_SQ   = BACK_RANK && (FILE == KING_FILE);
  localparam bit DBL_N     = (RANK == 3);
  localparam bit DBL_S     = (RANK == NRANKS - 2);
  localparam bit CAS_E_TGT = (FILE == KING_FILE + 2);
  localparam bit CAS_W_TGT = (FILE == KING_FILE - 2);
`ifdef MOVEGEN_PROMO_EN
  // bits 0,2,5 promote travelling north on the last rank; bits 1,3,4 travelling south on rank 1
  localparam logic [31:0] PROMO_MASK = ((RANK == NRANKS) ? 32'h0000_0025 : 32'h0000_0000) |
                                       ((RANK == 1)      ? 32'h0000_001A : 32'h0000_0000);
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  logic [3:0]  pos_r;
  logic [31:0] pend_r, pend_nxt, cap_s;
  state_t      state_r, state_nxt;
  logic        empty_s, oppos_s, dest_s;
  logic [4:0]  cur_idx_s, nxt_idx_s;
  logic [5:0]  nxt_rec_s;
  logic        valid_r, busy_r;
  logic [2:0]  kind_r, dir_r;
  logic [1:0]  promo_r;
`ifdef MOVEGEN_PROMO_EN
  logic [1:0]  promo_cnt_r, promo_nxt;
`endif

  function automatic logic [4:0] low_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) idx = v[i] ? 5'(i) : idx;
    return idx;
  endfunction

  // Map a pending-vector index onto {kind, dir}.
  function automatic logic [5:0] rec_of(input logic [4:0] idx);
    logic [5:0] r;
    if (idx < 5'd2)       r = {3'd0, 3'(idx)};
    else if (idx < 5'd6)  r = {3'd1, 3'(idx - 5'd2)};
    else if (idx < 5'd14) r = {3'd2, 3'(idx - 5'd6)};
    else if (idx < 5'd22) r = {3'd3, 3'(idx - 5'd14)};
    else if (idx < 5'd30) r = {3'd4, 3'(idx - 5'd22)};
    else                  r = {3'd5, 3'(idx - 5'd30)};
    return r;
  endfunction

  assign empty_s = (pos_r == 4'd0);
  assign oppos_s = !empty_s && (pos_r[3] != wtp);
  assign dest_s  = empty_s || oppos_s;
  assign out_pos_data = pos_r;
  assign o_mv_to      = TO_SQ;
  assign o_mv_valid   = valid_r;
  assign o_busy       = busy_r;
  assign o_mv_kind    = kind_r;
  assign o_mv_dir     = dir_r;
  assign o_mv_promo   = promo_r;

  // Square contents register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_r <= 4'd0;
    else if (in_pos_valid) pos_r <= in_pos_data;
    else pos_r <= pos_r;
  end

  // Source-phase signalling driven by the piece on this square.
  always_comb begin
    o_pawn_push = 2'b00;
    o_pawn_take = 4'b0000;
    o_king      = 8'h00;
    o_slide     = 8'h00;
    o_knight    = 8'h00;
    if (emit_move) begin
      o_pawn_push[0] = (pos_r == 4'hE) || (DBL_N && i_pawn_push[0] && empty_s);
      o_pawn_push[1] = (pos_r == 4'h6) || (DBL_S && i_pawn_push[1] && empty_s);
      o_pawn_take    = (pos_r == 4'hE) ? 4'b1001 : ((pos_r == 4'h6) ? 4'b0110 : 4'b0000);
      o_king         = (pos_r[2:0] == 3'd1) ? 8'hFF : 8'h00;
      o_knight       = (pos_r[2:0] == 3'd5) ? 8'hFF : 8'h00;
      o_slide        = (((pos_r[2:0] == 3'd2) || (pos_r[2:0] == 3'd3)) ? 8'h55 : 8'h00) |
                       (((pos_r[2:0] == 3'd2) || (pos_r[2:0] == 3'd4)) ? 8'hAA : 8'h00) |
                       ({8{empty_s}} & i_slide);
    end else begin
      o_pawn_push = 2'b00;
      o_slide     = 8'h00;
    end
  end

  // Castle lines originate at the king home squares and pass over empty back-rank squares.
  always_comb begin
    o_castle_e = 1'b0;
    o_castle_w = 1'b0;
    if (KING_SQ) begin
      o_castle_w = (RANK == 1) ? i_castle_rights[0] : i_castle_rights[2];
      o_castle_e = (RANK == 1) ? i_castle_rights[1] : i_castle_rights[3];
    end else if (BACK_RANK) begin
      o_castle_e = empty_s && i_castle_e;
      o_castle_w = empty_s && i_castle_w;
    end else begin
      o_castle_e = 1'b0;
      o_castle_w = 1'b0;
    end
  end

  assign cap_s = {CAS_W_TGT && i_castle_w && empty_s,
                  CAS_E_TGT && i_castle_e && empty_s,
                  i_knight & {8{dest_s}},
                  i_slide & {8{dest_s}},
                  i_king & {8{dest_s}},
                  i_pawn_take & {4{oppos_s}},
                  i_pawn_push & {2{empty_s}}};

  assign cur_idx_s = low_idx(pend_r);
  assign nxt_idx_s = low_idx(pend_nxt);
  assign nxt_rec_s = rec_of(nxt_idx_s);

  // Capture/drain sequencing; flush overrides capture and handshakes.
  always_comb begin
    state_nxt = state_r;
    pend_nxt  = pend_r;
`ifdef MOVEGEN_PROMO_EN
    promo_nxt = promo_cnt_r;
`endif
    if (flush) begin
      state_nxt = IDLE;
      pend_nxt  = 32'd0;
`ifdef MOVEGEN_PROMO_EN
      promo_nxt = 2'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (capture) begin
            pend_nxt  = cap_s;
            state_nxt = (cap_s != 32'd0) ? DRAIN : IDLE;
          end else begin
            state_nxt = IDLE;
          end
        end
        DRAIN: begin
          if (i_mv_ready) begin
`ifdef MOVEGEN_PROMO_EN
            if (PROMO_MASK[cur_idx_s] && (promo_cnt_r != 2'd3)) begin
              promo_nxt = promo_cnt_r + 2'd1;
            end else begin
              pend_nxt  = pend_r & ~(32'd1 << cur_idx_s);
              promo_nxt = 2'd0;
            end
`else
            pend_nxt = pend_r & ~(32'd1 << cur_idx_s);
`endif
            state_nxt = (pend_nxt != 32'd0) ? DRAIN : IDLE;
          end else begin
            state_nxt = DRAIN;
          end
        end
        default: begin
          state_nxt = IDLE;
          pend_nxt  = 32'd0;
        end
      endcase
    end
  end

  // State, pending flags and registered record fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pend_r  <= 32'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      kind_r  <= 3'd0;
      dir_r   <= 3'd0;
      promo_r <= 2'd0;
    end else begin
      state_r <= state_nxt;
      pend_r  <= pend_nxt;
      valid_r <= (state_nxt == DRAIN);
      busy_r  <= (state_nxt != IDLE);
      kind_r  <= nxt_rec_s[5:3];
      dir_r   <= nxt_rec_s[2:0];
`ifdef MOVEGEN_PROMO_EN
      promo_r <= promo_nxt;
`else
      promo_r <= 2'd0;
`endif
    end
  end

`ifdef MOVEGEN_PROMO_EN
  // Promotion piece counter for the record currently presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) promo_cnt_r <= 2'd0;
    else promo_cnt_r <= promo_nxt;
  end
`endif

endmodule

// File: tb/tb_movegen_square_seq.sv
// Directed bench for movegen_square_seq: instances at e4 (idx 0), h8 (idx 1) and g1 (idx 2).
module tb_movegen_square_seq;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] in_pos_data;
  logic [2:0] pos_valid, cap, rdy, flsh;
  logic wtp, emit_move, i_ce, i_cw;
  logic [3:0] castle_rights, i_take;
  logic [1:0] i_push;
  logic [7:0] i_kg, i_sl, i_kn;

  logic [3:0] opos [3];
  logic [1:0] o_push [3];
  logic [3:0] o_take [3];
  logic [7:0] o_kg [3], o_sl [3], o_kn [3];
  logic       o_ce [3], o_cw [3], busy [3], valid [3];
  logic [5:0] mv_to [3];
  logic [2:0] kind [3], dir [3];
  logic [1:0] promo [3];

  int total = 0;
  int bad = 0;
  logic [8:0] got;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_sq
    movegen_square_seq #(
      .RANK((g == 0) ? 4 : ((g == 1) ? 8 : 1)),
      .FILE((g == 0) ? 5 : ((g == 1) ? 8 : 7))
    ) u_sq (
      .clk(clk), .rst(rst), .in_pos_valid(pos_valid[g]), .in_pos_data(in_pos_data),
      .out_pos_data(opos[g]), .wtp(wtp), .emit_move(emit_move), .capture(cap[g]),
      .flush(flsh[g]), .i_castle_rights(castle_rights),
      .o_pawn_push(o_push[g]), .i_pawn_push(i_push), .o_pawn_take(o_take[g]), .i_pawn_take(i_take),
      .o_king(o_kg[g]), .i_king(i_kg), .o_slide(o_sl[g]), .i_slide(i_sl),
      .o_knight(o_kn[g]), .i_knight(i_kn), .o_castle_e(o_ce[g]), .o_castle_w(o_cw[g]),
      .i_castle_e(i_ce), .i_castle_w(i_cw), .o_busy(busy[g]), .o_mv_valid(valid[g]),
      .i_mv_ready(rdy[g]), .o_mv_to(mv_to[g]), .o_mv_kind(kind[g]), .o_mv_dir(dir[g]),
      .o_mv_promo(promo[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pos(input int s, input logic [3:0] p);
    in_pos_data = p;
    pos_valid[s] = 1'b1;
    step();
    pos_valid[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({valid[s], busy[s], kind[s], dir[s], promo[s], opos[s]} !== 14'd0) begin
        bad++;
        $display("FAIL reset[%0d] got=%h exp=0", s, {valid[s], busy[s], kind[s], dir[s], promo[s], opos[s]});
      end
    end
    total++;
    if ({mv_to[0], mv_to[1], mv_to[2]} !== {6'd28, 6'd63, 6'd6}) begin
      bad++;
      $display("FAIL mv_to got=%0d,%0d,%0d exp=28,63,6", mv_to[0], mv_to[1], mv_to[2]);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sources();
    emit_move = 1'b1;
    load_pos(0, 4'hA);
    total++;
    if ({opos[0], o_sl[0], o_kg[0]} !== {4'hA, 8'hFF, 8'h00}) begin
      bad++; $display("FAIL src_queen got pos=%h sl=%h kg=%h exp A FF 00", opos[0], o_sl[0], o_kg[0]);
    end
    load_pos(0, 4'hB);
    total++;
    if (o_sl[0] !== 8'h55) begin bad++; $display("FAIL src_rook got=%h exp=55", o_sl[0]); end
    load_pos(0, 4'hE);
    total++;
    if ({o_push[0], o_take[0]} !== {2'b01, 4'b1001}) begin
      bad++; $display("FAIL src_wpawn got push=%b take=%b exp 01 1001", o_push[0], o_take[0]);
    end
    load_pos(0, 4'h5);
    total++;
    if ({o_kn[0], o_sl[0]} !== {8'hFF, 8'h00}) begin
      bad++; $display("FAIL src_knight got kn=%h sl=%h exp FF 00", o_kn[0], o_sl[0]);
    end
    load_pos(0, 4'h0);
    i_sl = 8'h3C;
    #1;
    total++;
    if (o_sl[0] !== 8'h3C) begin bad++; $display("FAIL src_pass got=%h exp=3C", o_sl[0]); end
    emit_move = 1'b0;
    #1;
    total++;
    if (o_sl[0] !== 8'h00) begin bad++; $display("FAIL src_gate got=%h exp=00", o_sl[0]); end
    i_sl = 8'h00;
  endtask

  task automatic test_drain();
    wtp = 1'b1;
    i_sl = 8'h05; i_kn = 8'h04;
    rdy[0] = 1'b1; cap[0] = 1'b1;
    step();
    cap[0] = 1'b0;
    got = {valid[0], kind[0], dir[0], promo[0]};
    total++; if (got !== {1'b1, 3'd3, 3'd0, 2'd0}) begin bad++; $display("FAIL drain_r1 got=%h exp=%h", got, {1'b1, 3'd3, 3'd0, 2'd0}); end
    step();
    got = {valid[0], kind[0], dir[0], promo[0]};
    total++; if (got !== {1'b1, 3'd3, 3'd2, 2'd0}) begin bad++; $display("FAIL drain_r2 got=%h exp=%h", got, {1'b1, 3'd3, 3'd2, 2'd0}); end
    step();
    got = {valid[0], kind[0], dir[0], promo[0]};
    total++; if (got !== {1'b1, 3'd4, 3'd2, 2'd0}) begin bad++; $display("FAIL drain_r3 got=%h exp=%h", got, {1'b1, 3'd4, 3'd2, 2'd0}); end
    step();
    total++; if ({valid[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL drain_end got=%b exp=00", {valid[0], busy[0]}); end
  endtask

  task automatic test_occupied();
    load_pos(0, 4'h9);
    cap[0] = 1'b1;
    step();
    cap[0] = 1'b0;
    total++; if ({valid[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL own_piece got=%b exp=00", {valid[0], busy[0]}); end
    step();
    total++; if ({valid[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL own_piece2 got=%b exp=00", {valid[0], busy[0]}); end
    load_pos(0, 4'h0);
  endtask

  task automatic test_backpressure();
    rdy[0] = 1'b0; cap[0] = 1'b1;
    step();
    cap[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      got = {valid[0], kind[0], dir[0], promo[0]};
      total++; if (got !== {1'b1, 3'd3, 3'd0, 2'd0}) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", k, got, {1'b1, 3'd3, 3'd0, 2'd0}); end
      cap[0] = (k == 1) || (k == 2);
      i_kn = (k == 1) ? 8'hFF : 8'h04;
      step();
    end
    cap[0] = 1'b0;
    rdy[0] = 1'b1;
    step();
    got = {valid[0], kind[0], dir[0], promo[0]};
    total++; if (got !== {1'b1, 3'd3, 3'd2, 2'd0}) begin bad++; $display("FAIL bp_r2 got=%h exp=%h", got, {1'b1, 3'd3, 3'd2, 2'd0}); end
    step();
    got = {valid[0], kind[0], dir[0], promo[0]};
    total++; if (got !== {1'b1, 3'd4, 3'd2, 2'd0}) begin bad++; $display("FAIL bp_r3 got=%h exp=%h", got, {1'b1, 3'd4, 3'd2, 2'd0}); end
    step();
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL bp_end got=%b exp=0", valid[0]); end
  endtask

  task automatic test_reset_mid();
    rdy[0] = 1'b0; cap[0] = 1'b1;
    step();
    cap[0] = 1'b0;
    total++; if (valid[0] !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", valid[0]); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({valid[0], busy[0], kind[0], dir[0]} !== 8'd0) begin
      bad++; $display("FAIL rstmid_now got=%h exp=0", {valid[0], busy[0], kind[0], dir[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL rstmid_post got=%b exp=0", valid[0]); end
    cap[0] = 1'b1; rdy[0] = 1'b1;
    step();
    cap[0] = 1'b0;
    got = {valid[0], kind[0], dir[0], promo[0]};
    total++; if (got !== {1'b1, 3'd3, 3'd0, 2'd0}) begin bad++; $display("FAIL rstmid_r1 got=%h exp=%h", got, {1'b1, 3'd3, 3'd0, 2'd0}); end
    step(); step(); step();
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL rstmid_end got=%b exp=0", valid[0]); end
  endtask

  task automatic test_flush();
    rdy[0] = 1'b0; cap[0] = 1'b1;
    step();
    total++; if (valid[0] !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", valid[0]); end
    flsh[0] = 1'b1;
    step();
    total++; if ({valid[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL flush_drain got=%b exp=00", {valid[0], busy[0]}); end
    step();
    total++; if ({valid[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL flush_vs_cap got=%b exp=00", {valid[0], busy[0]}); end
    flsh[0] = 1'b0; cap[0] = 1'b0;
    i_sl = 8'h00; i_kn = 8'h00;
    step();
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL flush_after got=%b exp=0", valid[0]); end
  endtask

  task automatic test_promo();
    i_push = 2'b01; rdy[1] = 1'b1; cap[1] = 1'b1;
    step();
    cap[1] = 1'b0;
`ifdef MOVEGEN_PROMO_EN
    for (int p = 0; p < 4; p++) begin
      got = {valid[1], kind[1], dir[1], promo[1]};
      total++; if (got !== {1'b1, 3'd0, 3'd0, 2'(p)}) begin bad++; $display("FAIL promo_r%0d got=%h exp=%h", p, got, {1'b1, 3'd0, 3'd0, 2'(p)}); end
      step();
    end
`else
    got = {valid[1], kind[1], dir[1], promo[1]};
    total++; if (got !== {1'b1, 3'd0, 3'd0, 2'd0}) begin bad++; $display("FAIL promo_r0 got=%h exp=%h", got, {1'b1, 3'd0, 3'd0, 2'd0}); end
    step();
`endif
    total++; if ({valid[1], promo[1]} !== 3'b000) begin bad++; $display("FAIL promo_end got=%b exp=000", {valid[1], promo[1]}); end
    i_push = 2'b00;
  endtask

  task automatic test_castle();
    i_ce = 1'b1;
    #1;
    total++;
    if ({o_ce[2], o_cw[2], o_ce[1], o_ce[0]} !== 4'b1010) begin
      bad++; $display("FAIL castle_lines got=%b exp=1010", {o_ce[2], o_cw[2], o_ce[1], o_ce[0]});
    end
    rdy[2] = 1'b0; cap[2] = 1'b1;
    step();
    cap[2] = 1'b0;
    got = {valid[2], kind[2], dir[2], promo[2]};
    total++; if (got !== {1'b1, 3'd5, 3'd0, 2'd0}) begin bad++; $display("FAIL castle_rec got=%h exp=%h", got, {1'b1, 3'd5, 3'd0, 2'd0}); end
    rdy[2] = 1'b1; flsh[2] = 1'b1;
    step();
    flsh[2] = 1'b0; rdy[2] = 1'b0; i_ce = 1'b0;
    total++; if ({valid[2], busy[2]} !== 2'b00) begin bad++; $display("FAIL castle_flush got=%b exp=00", {valid[2], busy[2]}); end
    step();
    total++; if (valid[2] !== 1'b0) begin bad++; $display("FAIL castle_after got=%b exp=0", valid[2]); end
  endtask

  initial begin
    rst = 1'b1;
    in_pos_data = 4'd0; pos_valid = 3'b000; cap = 3'b000; rdy = 3'b000; flsh = 3'b000;
    wtp = 1'b1; emit_move = 1'b0; i_ce = 1'b0; i_cw = 1'b0;
    castle_rights = 4'b0000; i_take = 4'd0; i_push = 2'd0;
    i_kg = 8'd0; i_sl = 8'd0; i_kn = 8'd0;
    test_reset();
    test_sources();
    test_drain();
    test_occupied();
    test_backpressure();
    test_reset_mid();
    test_flush();
    test_promo();
    test_castle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/movegen_square_seq.md
# movegen_square_seq

Parametrised, registered successor to the per-square move generator cell: one instance per board square, tiled over an NRANKS x NFILES grid. It keeps the combinational pawn/king/slider/knight/castle signalling to neighbours. When the square is a legal destination, it latches which incoming direction lines fired and serialises them into move records over a valid/ready port. A downstream move-list collector resolves source squares and assembles the move list.

## Interface
Parameters:
- RANK, 1: rank of this square, 1..NRANKS.
- FILE, 1: file of this square, 1..NFILES.
- NRANKS, 8: board height.
- NFILES, 8: board width.
- KING_FILE, 5: king home file for castling.
- SQ_W, 6: width of square index, >= clog2(NRANKS*NFILES).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- in_pos_valid, in, 1: load in_pos_data into the square register.
- in_pos_data, in, 4: piece code {colour, piece[2:0]}; 0 = empty; K,Q,R,B,N,P = 1..6; +8 = white.
- out_pos_data, out, 4: registered square contents (serial chain).
- wtp, in, 1: white to play.
- emit_move, in, 1: combinational source phase enable.
- capture, in, 1: one-cycle strobe that latches destination flags.
- flush, in, 1: synchronous abort of pending records.
- i_castle_rights, in, 4: [0] W-long, [1] W-short, [2] B-long, [3] B-short.
- o_pawn_push / i_pawn_push, out/in, 2: [0] north-travelling, [1] south-travelling.
- o_pawn_take / i_pawn_take, out/in, 4: travelling NE, SE, SW, NW.
- o_king / i_king, out/in, 8: direction d = N, NE, E, SE, S, SW, W, NW (index 0..7).
- o_slide / i_slide, out/in, 8: same indexing as king.
- o_knight / i_knight, out/in, 8: NNE, NEE, SEE, SSE, SSW, SWW, NWW, NNW.
- o_castle_e, o_castle_w / i_castle_e, i_castle_w, out/in, 1 each: castle propagation lines.
- o_busy, out, 1: state != IDLE.
- o_mv_valid, out, 1: move record valid.
- i_mv_ready, in, 1: collector accepts the record.
- o_mv_to, out, SQ_W: (RANK-1)*NFILES + (FILE-1), constant.
- o_mv_kind, out, 3: 0 push, 1 pawn take, 2 king, 3 slide, 4 knight, 5 castle.
- o_mv_dir, out, 3: direction index within the kind (castle: 0 = E, 1 = W).
- o_mv_promo, out, 2: 0 Q, 1 R, 2 B, 3 N; 0 when not a promotion.

## Operation
- Square register: loads on in_pos_valid in any state. Pending flags are unaffected by a load.
- Square flags:
  - empty = pos==0.
  - oppos = occupied and pos[3] != wtp.
- Source outputs (combinational, gated by emit_move):
  - White pawn (0xE) drives push[0], take[0] and take[3]. Black pawn (0x6) drives push[1], take[1] and take[2].
  - Double push: o_pawn_push[0] is also driven by i_pawn_push[0]&empty when RANK==3. o_pawn_push[1] is also driven by i_pawn_push[1]&empty when RANK==NRANKS-2.
  - King drives all o_king. Knight drives all o_knight.
  - Q/R drive slide 0, 2, 4 and 6. Q/B drive slide 1, 3, 5 and 7.
  - Slider pass-through: o_slide[d] |= empty & i_slide[d].
- Castling:
  - At (1, KING_FILE): o_castle_w = rights[0], o_castle_e = rights[1].
  - At (NRANKS, KING_FILE): o_castle_w = rights[2], o_castle_e = rights[3].
  - Other squares on ranks 1 and NRANKS: o_castle_e = empty&i_castle_e, o_castle_w = empty&i_castle_w.
  - Castle target: FILE==KING_FILE+2 with i_castle_e, or FILE==KING_FILE-2 with i_castle_w.
  - All castle lines are 0 elsewhere.
- Destination mask:
  - pawn push needs empty.
  - pawn take needs oppos.
  - king, slide and knight need empty|oppos.
  - castle needs empty.
- Pending vector: 32 bits in priority order: push[0..1], take[0..3], king[0..7], slide[0..7], knight[0..7], castle E, W. Lowest set bit is presented first.
- FSM:
  - IDLE: on capture, latch the masked inputs. Go to DRAIN if non-zero, else stay.
  - DRAIN: o_mv_valid=1, presenting the lowest pending bit. On valid&ready, clear that bit. When the last bit clears, go to IDLE.
- capture while in DRAIN is ignored.
- flush: clears the pending flags and the promo counter, and forces IDLE. flush has priority over capture and over handshakes in the same cycle.

## Timing
- Reset values: pos=0, pending=0, IDLE, promo counter 0, o_mv_valid=0, o_busy=0, o_mv_kind/dir/promo=0.
- capture at cycle N: o_mv_valid is high from N+1.
- One record per cycle while i_mv_ready is held high.
- o_mv_valid falls the cycle after the final handshake.
- Record fields are stable while valid&!ready (no retraction, no change).
- Throughput: k pending bits drain in k cycles with ready held high (plus 3 extra cycles per promotion bit when MOVEGEN_PROMO_EN is defined).
- rst mid-DRAIN: immediate return to reset values.

## Configuration
- MOVEGEN_PROMO_EN defined:
  - Promotion pending bits are: push[0]/take[0]/take[3] at RANK==NRANKS, and push[1]/take[1]/take[2] at RANK==1.
  - Each such bit emits 4 records with o_mv_promo 0, 1, 2, 3. The bit clears only on the 4th handshake.
- Undefined: every pending bit emits one record with o_mv_promo=0, and there is no promo counter.

## Test plan
- Reset mid-DRAIN with 3 bits pending → o_mv_valid=0 and o_busy=0 immediately; after release, the next capture behaves normally.
- e4 square (RANK=4, FILE=5) empty, wtp=1, i_slide=8'h05, i_knight[2]=1, capture, ready=1 → three records: (3,0), (3,2), (4,2), to=28; valid low after the 3rd handshake.
- Same square holding a white piece (0x9) → capture yields no records and stays IDLE.
- Backpressure: ready=0 for 5 cycles during DRAIN → kind/dir held constant; capture pulses in that window are ignored.
- RANK=8 square empty, i_pawn_push[0]=1, promo enabled → 4 records, kind 0 with promo 0, 1, 2, 3. With the macro undefined → a single record with promo 0.
- Castling: g1 empty, i_castle_e=1 → one record, kind 5, dir 0. flush asserted in the same cycle as the handshake → IDLE and pending cleared.
